mac_unit: RTL and testbench

- Single-cycle registered multiply-accumulate for the DSP datapath of the RISC-V core.
- Computes result = a*b + c in one of four signed/unsigned/fixed-point modes.
- Supports optional saturation and rounding, and reports overflow/underflow flags.
- Fed by the DSP execute stage; the result goes to writeback.

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_sat.sv | 42 ++++
 rtl/mac_unit.sv | 137 +++++++++++++
 tb/tb_mac_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate unit: widths, mode encodings,
// saturation limits and mode-decoding helpers.
package mac_pkg;

    localparam int unsigned MAC_DATA_W = 32;
    localparam int unsigned MAC_FRAC_W = 16;
    localparam int unsigned MAC_MODE_W = 2;

    localparam logic [MAC_MODE_W-1:0] MAC_MODE_SINT  = 2'b00;
    localparam logic [MAC_MODE_W-1:0] MAC_MODE_UQ    = 2'b01;
    localparam logic [MAC_MODE_W-1:0] MAC_MODE_MIXED = 2'b10;
    localparam logic [MAC_MODE_W-1:0] MAC_MODE_SQ    = 2'b11;

    localparam logic [MAC_DATA_W-1:0] SMAX = 32'h7FFF_FFFF;
    localparam logic [MAC_DATA_W-1:0] SMIN = 32'h8000_0000;
    localparam logic [MAC_DATA_W-1:0] UMAX = 32'hFFFF_FFFF;

    // Q-format modes carry FRAC_W fractional bits and need the post-multiply shift.
    function automatic logic mac_is_q(input logic [MAC_MODE_W-1:0] mode);
        return (mode == MAC_MODE_UQ) || (mode == MAC_MODE_SQ);
    endfunction

    // Every mode except unsigned Q treats a and c as two's complement.
    function automatic logic mac_is_signed(input logic [MAC_MODE_W-1:0] mode);
        return (mode != MAC_MODE_UQ);
    endfunction

    // b is signed only in the fully signed modes; the mixed mode takes it unsigned.
    function automatic logic mac_b_signed(input logic [MAC_MODE_W-1:0] mode);
        return (mode == MAC_MODE_SINT) || (mode == MAC_MODE_SQ);
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Range check and clamp/wrap of the exact MAC sum into the result width.
module mac_sat
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned SUM_W  = 2 * MAC_DATA_W + 2
) (
    input  logic signed [SUM_W-1:0]  sum_i,
    input  logic                     is_signed_i,
    input  logic                     saturate_i,
    output logic        [DATA_W-1:0] result_c_o,
    output logic                     overflow_c_o,
    output logic                     underflow_c_o
);

    localparam int unsigned EXT_W = SUM_W - DATA_W;

    localparam logic signed [SUM_W-1:0] SMAX_EXT = {{EXT_W{1'b0}}, DATA_W'(SMAX)};
    localparam logic signed [SUM_W-1:0] SMIN_EXT = {{EXT_W{1'b1}}, DATA_W'(SMIN)};
    localparam logic signed [SUM_W-1:0] UMAX_EXT = {{EXT_W{1'b0}}, DATA_W'(UMAX)};

    // Flag out-of-range sums and clamp when saturation is requested, else wrap.
    always_comb begin
        result_c_o    = sum_i[DATA_W-1:0];
        overflow_c_o  = 1'b0;
        underflow_c_o = 1'b0;

        if (is_signed_i) begin
            overflow_c_o  = (sum_i > SMAX_EXT);
            underflow_c_o = (sum_i < SMIN_EXT);
        end else begin
            overflow_c_o  = (sum_i > UMAX_EXT);
        end

        if (saturate_i && overflow_c_o) begin
            result_c_o = is_signed_i ? DATA_W'(SMAX) : DATA_W'(UMAX);
        end else if (saturate_i && underflow_c_o) begin
            result_c_o = DATA_W'(SMIN);
        end
    end

endmodule

// File: rtl/mac_unit.sv
// Registered multiply-accumulate: result = a*b + c in signed/unsigned/mixed
// integer or Q-format, with optional rounding, saturation and range flags.
// Define MAC_PIPE_EN to insert a register stage after the multiplier
// (latency 2 instead of 1).
module mac_unit
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned FRAC_W = MAC_FRAC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [DATA_W-1:0]     c,
    input  logic [MAC_MODE_W-1:0] mode,
    input  logic                  saturate,
    input  logic                  round,
    output logic [DATA_W-1:0]     result,
    output logic                  overflow,
    output logic                  underflow
);

    // Two extra bits over the full product keep every exact sum representable.
    localparam int unsigned SUM_W = 2 * DATA_W + 2;
    localparam int unsigned EXT_W = SUM_W - DATA_W;

    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) << (FRAC_W - 1);

    logic signed [SUM_W-1:0] a_ext;
    logic signed [SUM_W-1:0] b_ext;
    logic signed [SUM_W-1:0] prod_d;

    logic signed [SUM_W-1:0] prod_s2;
    logic [MAC_MODE_W-1:0]   mode_s2;
    logic [DATA_W-1:0]       c_s2;
    logic                    sat_s2;
    logic                    rnd_s2;

    logic signed [SUM_W-1:0] c_ext;
    logic signed [SUM_W-1:0] prod_rnd;
    logic signed [SUM_W-1:0] sum_d;

    logic [DATA_W-1:0] result_d;
    logic              overflow_d;
    logic              underflow_d;

    logic [DATA_W-1:0] result_q;
    logic              overflow_q;
    logic              underflow_q;

    // Mode-dependent operand extension and the exact product.
    always_comb begin
        a_ext  = {{EXT_W{mac_is_signed(mode) & a[DATA_W-1]}}, a};
        b_ext  = {{EXT_W{mac_b_signed(mode) & b[DATA_W-1]}}, b};
        prod_d = a_ext * b_ext;
    end

`ifdef MAC_PIPE_EN
    logic signed [SUM_W-1:0] prod_q;
    logic [MAC_MODE_W-1:0]   mode_q;
    logic [DATA_W-1:0]       c_q;
    logic                    sat_q;
    logic                    rnd_q;

    // Product stage register; the controls travel with the product they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            mode_q <= '0;
            c_q    <= '0;
            sat_q  <= 1'b0;
            rnd_q  <= 1'b0;
        end else if (enable) begin
            prod_q <= prod_d;
            mode_q <= mode;
            c_q    <= c;
            sat_q  <= saturate;
            rnd_q  <= round;
        end
    end

    assign prod_s2 = prod_q;
    assign mode_s2 = mode_q;
    assign c_s2    = c_q;
    assign sat_s2  = sat_q;
    assign rnd_s2  = rnd_q;
`else
    assign prod_s2 = prod_d;
    assign mode_s2 = mode;
    assign c_s2    = c;
    assign sat_s2  = saturate;
    assign rnd_s2  = round;
`endif

    // Q modes round half-up before the fractional shift; integer modes add one LSB.
    always_comb begin
        c_ext    = {{EXT_W{mac_is_signed(mode_s2) & c_s2[DATA_W-1]}}, c_s2};
        prod_rnd = prod_s2 + (rnd_s2 ? RND_HALF : SUM_W'(0));
        if (mac_is_q(mode_s2)) begin
            sum_d = (prod_rnd >>> FRAC_W) + c_ext;
        end else begin
            sum_d = prod_s2 + c_ext + SUM_W'(rnd_s2);
        end
    end

    mac_sat #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_sat (
        .sum_i         (sum_d),
        .is_signed_i   (mac_is_signed(mode_s2)),
        .saturate_i    (sat_s2),
        .result_c_o    (result_d),
        .overflow_c_o  (overflow_d),
        .underflow_c_o (underflow_d)
    );

    // Output register; holds its value while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (enable) begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed self-checking bench for mac_unit.
module tb_mac_unit;

`ifdef MAC_PIPE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [1:0]  mode;
    logic        saturate;
    logic        round;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    mac_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .saturate  (saturate),
        .round     (round),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] r, input logic ov, input logic un);
        check({tag, ".result"}, result, r);
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
        check({tag, ".underflow"}, 32'(underflow), 32'(un));
    endtask

    // Drive one operation at the falling edge, then wait out the pipeline latency.
    task automatic apply(input logic [1:0] md, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] cc, input logic sat, input logic rnd);
        @(negedge clk);
        enable   = 1'b1;
        mode     = md;
        a        = aa;
        b        = bb;
        c        = cc;
        saturate = sat;
        round    = rnd;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        mode     = 2'b00;
        saturate = 1'b0;
        round    = 1'b0;

        repeat (2) @(negedge clk);
        check_all("reset", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        apply(2'b00, 32'h0000_1000, 32'h2, 32'h0, 1'b0, 1'b0);
        check_all("sint_basic", 32'h0000_2000, 1'b0, 1'b0);

        apply(2'b00, 32'h0000_1000, 32'h3, 32'h0000_2000, 1'b0, 1'b0);
        check_all("sint_acc", 32'h0000_5000, 1'b0, 1'b0);

        apply(2'b01, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 1'b0, 1'b0);
        check_all("uq_mul_one", 32'hFFFF_0000, 1'b0, 1'b0);

        apply(2'b00, 32'h7FFF_FFFF, 32'h2, 32'h0, 1'b0, 1'b0);
        check_all("sint_ovf_wrap", 32'hFFFF_FFFE, 1'b1, 1'b0);

        apply(2'b00, 32'h7FFF_FFFF, 32'h2, 32'h0, 1'b1, 1'b0);
        check_all("sint_ovf_sat", 32'h7FFF_FFFF, 1'b1, 1'b0);

        apply(2'b00, 32'h1, 32'h1, 32'h1, 1'b0, 1'b1);
        check_all("sint_round", 32'h0000_0003, 1'b0, 1'b0);

        apply(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        check_all("sint_neg_neg", 32'h0000_0001, 1'b0, 1'b0);

        apply(2'b10, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 1'b0);
        check_all("mixed_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Mixed mode: b=0xFFFFFFFF is 2^32-1, so -1 * (2^32-1) underflows.
        apply(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        check_all("mixed_unf", 32'h0000_0001, 1'b0, 1'b1);

        // 1 * 0x8000 = 0.5 LSB after the Q shift: truncates to 0, rounds to 1.
        apply(2'b01, 32'h1, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
        check_all("uq_trunc", 32'h0000_0000, 1'b0, 1'b0);
        apply(2'b01, 32'h1, 32'h0000_8000, 32'h0, 1'b0, 1'b1);
        check_all("uq_round", 32'h0000_0001, 1'b0, 1'b0);

        // 0xFFFFFFFF (Q16.16) * 1.0 + 1 LSB exceeds the unsigned range.
        apply(2'b01, 32'hFFFF_FFFF, 32'h0001_0000, 32'h1, 1'b0, 1'b0);
        check_all("uq_ovf_wrap", 32'h0000_0000, 1'b1, 1'b0);
        apply(2'b01, 32'hFFFF_FFFF, 32'h0001_0000, 32'h1, 1'b1, 1'b0);
        check_all("uq_ovf_sat", 32'hFFFF_FFFF, 1'b1, 1'b0);

        // -0.5 * 3.0 + 1.0 = -0.5 in signed Q16.16.
        apply(2'b11, 32'hFFFF_8000, 32'h0003_0000, 32'h0001_0000, 1'b0, 1'b0);
        check_all("sq_neg", 32'hFFFF_8000, 1'b0, 1'b0);

        apply(2'b00, 32'h8000_0000, 32'h2, 32'h0, 1'b1, 1'b0);
        check_all("sint_unf_sat", 32'h8000_0000, 1'b0, 1'b1);

        // Hold: new operands with enable low must not disturb the outputs.
        @(negedge clk);
        enable = 1'b0;
        a      = 32'h0000_0005;
        b      = 32'h0000_0007;
        c      = 32'h0;
        mode   = 2'b00;
        saturate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("hold", 32'h8000_0000, 1'b0, 1'b1);

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_held", 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(2'b00, 32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 1'b0, 1'b0);
        check_all("after_reset", 32'h0000_0024, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
